// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage 16-bit pipeline.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       rs_ID,
  input  logic [1:0]       rt_ID,
  input  logic             use_rs_ID,
  input  logic             use_rt_ID,
  input  logic             is_halted_ID,
  input  logic             d_readM_EX,
  input  logic             RegWrite_EX,
  input  logic [1:0]       write_reg_addr_EX,
  input  logic             mispredict_EX,
  input  logic             i_mem_ready,
  input  logic             d_req_MEM,
  input  logic             d_mem_ready,
  input  logic             is_halted_WB,
  output logic             pc_write,
  output logic             stall_IF_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_MEM,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_EX_MEM,
  output logic             bubble_WB,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] DMEM_WAIT = 2'd1;
  localparam logic [1:0] DRAIN     = 2'd2;
  localparam logic [1:0] HALT      = 2'd3;

  logic [1:0] state_q, state_d;
  logic       ret_q, ret_d;  // 1: return to DRAIN after DMEM_WAIT, 0: return to RUN
  logic [1:0] eff_state;
  logic       d_wait;
  logic       load_use;

  assign d_wait   = d_req_MEM && !d_mem_ready;
  assign load_use = d_readM_EX && RegWrite_EX &&
                    ((use_rs_ID && (rs_ID == write_reg_addr_EX)) ||
                     (use_rt_ID && (rt_ID == write_reg_addr_EX)));

  // On release from DMEM_WAIT the lower-priority rules see the return state.
  assign eff_state = (state_q == DMEM_WAIT) ? (ret_q ? DRAIN : RUN) : state_q;

  always_comb begin
    pc_write     = 1'b1;
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_MEM = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    flush_EX_MEM = 1'b0;
    bubble_WB    = 1'b0;
    halted       = 1'b0;
    state_d      = state_q;
    ret_d        = ret_q;

    if (!reset_n) begin
      pc_write = 1'b0;
      state_d  = RUN;
      ret_d    = 1'b0;
    end else if (state_q == HALT) begin
      pc_write     = 1'b0;
      stall_IF_ID  = 1'b1;
      stall_ID_EX  = 1'b1;
      stall_EX_MEM = 1'b1;
      bubble_WB    = 1'b1;
      halted       = 1'b1;
    end else if (d_wait) begin
      pc_write     = 1'b0;
      stall_IF_ID  = 1'b1;
      stall_ID_EX  = 1'b1;
      stall_EX_MEM = 1'b1;
      bubble_WB    = 1'b1;
      state_d      = DMEM_WAIT;
      if (state_q != DMEM_WAIT) ret_d = (state_q == DRAIN);
    end else if (mispredict_EX) begin
      // Any pending HLT was on the wrong path, so drain is abandoned.
      flush_IF_ID = 1'b1;
      flush_ID_EX = 1'b1;
      state_d     = RUN;
    end else if (eff_state == DRAIN) begin
      pc_write    = 1'b0;
      flush_IF_ID = 1'b1;
      if (is_halted_WB) begin
        state_d = HALT;
        halted  = 1'b1;
      end else begin
        state_d = DRAIN;
      end
    end else begin
      state_d = RUN;
      if (load_use) begin
        pc_write    = 1'b0;
        stall_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
      end else if (!i_mem_ready) begin
        pc_write    = 1'b0;
        flush_IF_ID = 1'b1;
      end else if (is_halted_ID) begin
        pc_write    = 1'b0;
        flush_IF_ID = 1'b1;
        state_d     = DRAIN;
      end
      if (is_halted_WB) begin
        state_d = HALT;
        halted  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             flush_take;

  assign flush_take = reset_n && (state_q != HALT) && !d_wait && mispredict_EX;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write && (state_q != HALT) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_take && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`else
  assign stall_cycles = {CNT_W{1'b0}};
  assign flush_events = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random stimulus
// against a flag-based behavioural model; counters are narrowed to exercise saturation.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [1:0]    rs_ID, rt_ID, write_reg_addr_EX;
  logic          use_rs_ID, use_rt_ID, is_halted_ID, d_readM_EX, RegWrite_EX;
  logic          mispredict_EX, i_mem_ready, d_req_MEM, d_mem_ready, is_halted_WB;
  logic          pc_write, stall_IF_ID, stall_ID_EX, stall_EX_MEM;
  logic          flush_IF_ID, flush_ID_EX, flush_EX_MEM, bubble_WB, halted;
  logic [CW-1:0] stall_cycles, flush_events;

  pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .rs_ID(rs_ID), .rt_ID(rt_ID),
    .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID), .is_halted_ID(is_halted_ID),
    .d_readM_EX(d_readM_EX), .RegWrite_EX(RegWrite_EX),
    .write_reg_addr_EX(write_reg_addr_EX), .mispredict_EX(mispredict_EX),
    .i_mem_ready(i_mem_ready), .d_req_MEM(d_req_MEM), .d_mem_ready(d_mem_ready),
    .is_halted_WB(is_halted_WB), .pc_write(pc_write), .stall_IF_ID(stall_IF_ID),
    .stall_ID_EX(stall_ID_EX), .stall_EX_MEM(stall_EX_MEM), .flush_IF_ID(flush_IF_ID),
    .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM), .bubble_WB(bubble_WB),
    .halted(halted), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: processor is stopped / waiting on data / has an HLT in flight.
  bit m_halted, m_dwait, m_drain;
  int m_sc, m_fe;
  bit n_halted, n_dwait, n_drain, sc_inc, fe_inc;
  bit e_pc, e_sif, e_sid, e_sem, e_fif, e_fid, e_fem, e_bwb, e_halt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit lu;
    lu = d_readM_EX && RegWrite_EX &&
         ((use_rs_ID && rs_ID == write_reg_addr_EX) || (use_rt_ID && rt_ID == write_reg_addr_EX));
    {e_sif, e_sid, e_sem, e_fif, e_fid, e_fem, e_bwb, e_halt} = '0;
    e_pc = 1;
    n_halted = m_halted; n_dwait = m_dwait; n_drain = m_drain; fe_inc = 0;
    if (!reset_n) begin
      e_pc = 0; n_halted = 0; n_dwait = 0; n_drain = 0;
    end else if (m_halted) begin
      e_pc = 0; e_sif = 1; e_sid = 1; e_sem = 1; e_bwb = 1; e_halt = 1;
    end else if (d_req_MEM && !d_mem_ready) begin
      e_pc = 0; e_sif = 1; e_sid = 1; e_sem = 1; e_bwb = 1; n_dwait = 1;
    end else begin
      n_dwait = 0;
      if (mispredict_EX) begin
        e_fif = 1; e_fid = 1; n_drain = 0; fe_inc = 1;
      end else if (m_drain) begin
        e_pc = 0; e_fif = 1;
        if (is_halted_WB) begin e_halt = 1; n_halted = 1; n_drain = 0; end
      end else begin
        if (lu) begin e_pc = 0; e_sif = 1; e_fid = 1; end
        else if (!i_mem_ready) begin e_pc = 0; e_fif = 1; end
        else if (is_halted_ID) begin e_pc = 0; e_fif = 1; n_drain = 1; end
        if (is_halted_WB) begin e_halt = 1; n_halted = 1; n_drain = 0; end
      end
    end
    sc_inc = reset_n && !e_pc && !m_halted;
  endtask

  // Evaluate the model and compare every output mid-cycle.
  task automatic settle();
    #4;
    model_eval();
    chk("pc_write", pc_write, e_pc);
    chk("stall_IF_ID", stall_IF_ID, e_sif);
    chk("stall_ID_EX", stall_ID_EX, e_sid);
    chk("stall_EX_MEM", stall_EX_MEM, e_sem);
    chk("flush_IF_ID", flush_IF_ID, e_fif);
    chk("flush_ID_EX", flush_ID_EX, e_fid);
    chk("flush_EX_MEM", flush_EX_MEM, e_fem);
    chk("bubble_WB", bubble_WB, e_bwb);
    chk("halted", halted, e_halt);
    chk("stall_cycles", stall_cycles, m_sc);
    chk("flush_events", flush_events, m_fe);
  endtask

  task automatic advance();
    @(posedge clk);
    m_halted = n_halted; m_dwait = n_dwait; m_drain = n_drain;
    if (!reset_n) begin
      m_sc = 0; m_fe = 0;
    end else if (PERF) begin
      if (sc_inc && m_sc < (1 << CW) - 1) m_sc++;
      if (fe_inc && m_fe < (1 << CW) - 1) m_fe++;
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic clr();
    reset_n = 1; rs_ID = 0; rt_ID = 0; write_reg_addr_EX = 0;
    use_rs_ID = 0; use_rt_ID = 0; is_halted_ID = 0; d_readM_EX = 0; RegWrite_EX = 0;
    mispredict_EX = 0; i_mem_ready = 1; d_req_MEM = 0; d_mem_ready = 0; is_halted_WB = 0;
  endtask

  task automatic do_reset();
    clr(); reset_n = 0; cyc(); reset_n = 1;
  endtask

  task automatic set_lu(input logic [1:0] rs);
    d_readM_EX = 1; RegWrite_EX = 1; write_reg_addr_EX = 2'd1; rs_ID = rs; use_rs_ID = 1;
  endtask

  initial begin
    m_halted = 0; m_dwait = 0; m_drain = 0; m_sc = 0; m_fe = 0;
    @(posedge clk); #1;

    // Reset state
    clr(); reset_n = 0; settle();
    chk("lit_reset_pc", pc_write, 0);
    chk("lit_reset_halted", halted, 0);
    advance(); reset_n = 1;

    // Mispredict overrides load-use
    set_lu(2'd1); mispredict_EX = 1; settle();
    chk("lit_mp_pc", pc_write, 1);
    chk("lit_mp_fif", flush_IF_ID, 1);
    chk("lit_mp_fid", flush_ID_EX, 1);
    chk("lit_mp_sif", stall_IF_ID, 0);
    advance(); clr(); settle();
    chk("lit_mp_fe", flush_events, PERF ? 1 : 0);
    advance();

    // Load-use: one bubble, then none with a different rs
    set_lu(2'd1); settle();
    chk("lit_lu_pc", pc_write, 0);
    chk("lit_lu_sif", stall_IF_ID, 1);
    chk("lit_lu_fid", flush_ID_EX, 1);
    advance(); clr(); settle();
    chk("lit_lu_release", pc_write, 1);
    advance();
    set_lu(2'd2); settle();
    chk("lit_nolu_pc", pc_write, 1);
    chk("lit_nolu_sif", stall_IF_ID, 0);
    advance(); clr();

    // Data wait for 3 cycles
    do_reset();
    for (int i = 0; i < 3; i++) begin
      d_req_MEM = 1; d_mem_ready = 0; settle();
      chk("lit_dw_sem", stall_EX_MEM, 1);
      chk("lit_dw_bwb", bubble_WB, 1);
      advance();
    end
    d_mem_ready = 1; settle();
    chk("lit_dw_release_pc", pc_write, 1);
    chk("lit_dw_release_sif", stall_IF_ID, 0);
    advance(); clr(); settle();
    chk("lit_dw_stall_cycles", stall_cycles, PERF ? 3 : 0);
    advance();

    // HLT drain and stop
    do_reset();
    is_halted_ID = 1; settle();
    chk("lit_hlt_id_fif", flush_IF_ID, 1);
    advance(); is_halted_ID = 0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("lit_drain_fif", flush_IF_ID, 1);
      chk("lit_drain_pc", pc_write, 0);
      advance();
    end
    is_halted_WB = 1; settle();
    chk("lit_hlt_wb_halted", halted, 1);
    advance(); is_halted_WB = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("lit_halt_stays", halted, 1);
      chk("lit_halt_pc", pc_write, 0);
      advance();
    end

    // Wrong-path HLT
    do_reset();
    is_halted_ID = 1; cyc(); is_halted_ID = 0;
    mispredict_EX = 1; settle();
    chk("lit_wp_pc", pc_write, 1);
    advance(); mispredict_EX = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("lit_wp_halted", halted, 0);
      chk("lit_wp_run_pc", pc_write, 1);
      advance();
    end

    // Reset in the middle of a data wait
    d_req_MEM = 1; d_mem_ready = 0; cyc();
    reset_n = 0; settle();
    chk("lit_rst_dw_pc", pc_write, 0);
    chk("lit_rst_dw_sem", stall_EX_MEM, 0);
    chk("lit_rst_dw_bwb", bubble_WB, 0);
    advance(); clr(); settle();
    chk("lit_rst_after_pc", pc_write, 1);
    chk("lit_rst_after_sc", stall_cycles, 0);
    chk("lit_rst_after_fe", flush_events, 0);
    advance();

    // Random stimulus
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset_n           = ($urandom_range(0, 99) >= 2);
      rs_ID             = 2'($urandom_range(0, 3));
      rt_ID             = 2'($urandom_range(0, 3));
      write_reg_addr_EX = 2'($urandom_range(0, 3));
      use_rs_ID         = ($urandom_range(0, 1) == 1);
      use_rt_ID         = ($urandom_range(0, 1) == 1);
      d_readM_EX        = ($urandom_range(0, 99) < 30);
      RegWrite_EX       = ($urandom_range(0, 99) < 70);
      mispredict_EX     = ($urandom_range(0, 99) < 10);
      i_mem_ready       = ($urandom_range(0, 99) < 85);
      d_req_MEM         = ($urandom_range(0, 99) < 25);
      d_mem_ready       = ($urandom_range(0, 99) < 50);
      is_halted_ID      = ($urandom_range(0, 99) < 6);
      is_halted_WB      = ($urandom_range(0, 99) < 4);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage 16-bit pipeline. It drives the `stall`/`flush` inputs of the IF/ID, ID/EX and EX/MEM registers and the PC write enable. It handles load-use hazards, EX-stage branch mispredicts, instruction- and data-memory wait states, and HLT drain/stop. It sits beside the pipeline registers and consumes stage-tagged control signals from ID, EX, MEM and WB.

## Interface
- `CNT_W`, default 16: width of the saturating performance counters.

- `clk`  in  1  clock
- `reset_n`  in  1  synchronous, active-low reset
- `rs_ID`, `rt_ID`  in  2 each  source register addresses in ID
- `use_rs_ID`, `use_rt_ID`  in  1 each  instruction in ID reads rs / rt
- `is_halted_ID`  in  1  HLT decoded in ID
- `d_readM_EX`, `RegWrite_EX`  in  1 each  load / register-write in EX
- `write_reg_addr_EX`  in  2  destination register in EX
- `mispredict_EX`  in  1  branch/jump resolved in EX differs from predicted PC
- `i_mem_ready`  in  1  fetch data valid this cycle
- `d_req_MEM`  in  1  MEM stage accessing data memory
- `d_mem_ready`  in  1  data access completes this cycle
- `is_halted_WB`  in  1  HLT reached WB
- `pc_write`  out  1  PC register load enable
- `stall_IF_ID`, `stall_ID_EX`, `stall_EX_MEM`  out  1 each  hold register
- `flush_IF_ID`, `flush_ID_EX`, `flush_EX_MEM`  out  1 each  load bubble
- `bubble_WB`  out  1  MEM/WB loads a bubble
- `halted`  out  1  processor stopped
- `stall_cycles`, `flush_events`  out  CNT_W each  performance counters

## Operation
- FSM states: RUN, DMEM_WAIT, DRAIN, HALT. A 1-bit `ret` records the state to return to after DMEM_WAIT (RUN or DRAIN).
- Output controls are Mealy: they are combinational from the state plus inputs. Defaults are `pc_write`=1 and all other controls 0.
- Decision priority, highest first:
  1. HALT state: `pc_write`=0; all three stalls=1; `bubble_WB`=1; `halted`=1. Leaves HALT only on reset.
  2. Data wait (`d_req_MEM` && !`d_mem_ready`), in any non-HALT state: `pc_write`=0; all three stalls=1; `bubble_WB`=1. Next state is DMEM_WAIT; `ret` is loaded on entry from RUN or DRAIN.
  3. `mispredict_EX`: `pc_write`=1; `flush_IF_ID`=1; `flush_ID_EX`=1. If the current or return state is DRAIN, the next state is RUN, because the HLT was on the wrong path.
  4. DRAIN: `pc_write`=0; `flush_IF_ID`=1. Stays in DRAIN until `is_halted_WB`, then goes to HALT.
  5. Load-use, when `d_readM_EX` && `RegWrite_EX` && ((`use_rs_ID` && rs_ID==write_reg_addr_EX) || (`use_rt_ID` && rt_ID==write_reg_addr_EX)): `pc_write`=0; `stall_IF_ID`=1; `flush_ID_EX`=1.
  6. Fetch wait (!`i_mem_ready`): `pc_write`=0; `flush_IF_ID`=1.
  7. `is_halted_ID` in RUN: `pc_write`=0; `flush_IF_ID`=1; next state is DRAIN.
- DMEM_WAIT with `d_mem_ready`=1: the stall releases in the same cycle, the next state is `ret`, and rules 3–7 are evaluated that cycle.
- `is_halted_WB` in RUN, with no drain seen: go directly to HALT.

## Timing
- Controls act at the next posedge, when the pipeline registers sample them. The FSM and counters update on that same posedge.
- Load-use costs exactly 1 bubble. A mispredict costs 2 bubbles. Data wait costs one stall per cycle that `d_mem_ready`=0.
- HLT fetched with no mispredict: `halted` rises in the cycle HLT occupies WB, 3 cycles after `is_halted_ID`, and stays high.
- While `reset_n`=0 at a posedge: the state goes to RUN, `ret` and the counters clear, and all outputs are 0, including `pc_write`. A reset mid-DMEM_WAIT or mid-DRAIN returns to RUN with no residue.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cycles` increments on every cycle with `pc_write`=0 and state≠HALT.
  - `flush_events` increments on each cycle with `mispredict_EX` taking effect under rule 3.
  - Both counters saturate at 2^CNT_W−1.
- `HAZARD_PERF_CNT_EN` undefined: the counter logic is absent and both outputs are constant 0.

## Test plan
- Load-use: LWD $1 in EX (`d_readM_EX`=1, write_reg_addr_EX=1) with rs_ID=1 and `use_rs_ID`=1 -> exactly one cycle with `pc_write`=0, `stall_IF_ID`=1, `flush_ID_EX`=1. With rs_ID=2 -> no stall.
- Mispredict during load-use: both conditions in the same cycle -> `pc_write`=1, `flush_IF_ID`=1, `flush_ID_EX`=1, `stall_IF_ID`=0. With the macro on, `flush_events` goes 0→1.
- Data wait: `d_req_MEM`=1 and `d_mem_ready`=0 for 3 cycles, then 1 -> three cycles with all stalls=1 and `bubble_WB`=1, release on the 4th, and `stall_cycles`=3.
- HLT drain: `is_halted_ID` pulse, then `is_halted_WB` 3 cycles later -> `flush_IF_ID`=1 in each DRAIN cycle, `halted`=1 from the `is_halted_WB` cycle onward, and `pc_write` stays 0 afterwards.
- Wrong-path HLT: `is_halted_ID`, then `mispredict_EX` on the next cycle -> return to RUN, `pc_write`=1, and `halted` never asserts.
- Reset mid-operation: assert `reset_n`=0 for 1 cycle while in DMEM_WAIT -> all outputs 0 and counters 0. After release, with `i_mem_ready`=1 and no other hazards, `pc_write`=1.
